// File: rtl/arbitro_mux_memoria_if.sv
// Bus between the two producers/downstream consumer and the round-robin buffered arbiter.
// The master side pushes words and applies pause; the slave side is the arbiter.
interface arbitro_mux_memoria_if #(
  parameter int unsigned DATA_WIDTH = 2
);
  logic                  push0;
  logic [DATA_WIDTH-1:0] data_in0;
  logic                  full0;
  logic                  empty0;
  logic                  push1;
  logic [DATA_WIDTH-1:0] data_in1;
  logic                  full1;
  logic                  empty1;
  logic                  pause;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  selector;
  logic                  overflow;

  modport master (
    output push0, data_in0, push1, data_in1, pause,
    input  full0, empty0, full1, empty1, data_out, valid_out, selector, overflow
  );

  modport slave (
    input  push0, data_in0, push1, data_in1, pause,
    output full0, empty0, full1, empty1, data_out, valid_out, selector, overflow
  );
endinterface

// File: rtl/arbitro_mux_memoria.sv
// Two-lane FIFO-buffered arbiter: quantum-limited round-robin pops one word per cycle
// onto a registered output and reports the granted lane as the mux selector.
module arbitro_mux_memoria #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned QUANTUM    = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  arbitro_mux_memoria_if.slave  bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = $clog2(QUANTUM + 1);

  logic [DATA_WIDTH-1:0] mem_q [2][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q [2];
  logic [PW-1:0]         wr_ptr_d [2];
  logic [PW-1:0]         rd_ptr_q [2];
  logic [PW-1:0]         rd_ptr_d [2];
  logic [CW-1:0]         cnt_q [2];
  logic [CW-1:0]         cnt_d [2];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  sel_q, sel_d;
  logic                  ovf_q, ovf_d;
  logic [RW-1:0]         racha_q, racha_d;

  logic [DATA_WIDTH-1:0] din [2];
  logic [1:0]            push, full, empty, push_ok, pop;
  logic                  eligible, grant;

  assign push   = {bus.push1, bus.push0};
  assign din[0] = bus.data_in0;
  assign din[1] = bus.data_in1;

  // Lane status and grant decision, all from pre-edge state
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i]   = (cnt_q[i] == CW'(0));
      full[i]    = (cnt_q[i] == CW'(FIFO_DEPTH));
      push_ok[i] = push[i] && !full[i];
    end
    eligible = !bus.pause && (!empty[0] || !empty[1]);
    grant    = sel_q;
    if (!empty[sel_q] && (empty[~sel_q] || (racha_q < RW'(QUANTUM)))) begin
      grant = sel_q;
    end else if (!empty[~sel_q]) begin
      grant = ~sel_q;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    sel_d      = sel_q;
    racha_d    = racha_q;
    ovf_d      = ovf_q | (|(push & full));
    for (int i = 0; i < 2; i++) begin
      pop[i]      = eligible && (grant == 1'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_ok[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
    end
    if (eligible) begin
      data_out_d = mem_q[grant][rd_ptr_q[grant]];
      valid_d    = 1'b1;
      sel_d      = grant;
      if (grant == sel_q) begin
        racha_d = (racha_q == RW'(QUANTUM)) ? racha_q : racha_q + RW'(1);
      end else begin
        racha_d = RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      data_out_q <= '0;
      valid_q    <= 1'b0;
      sel_q      <= 1'b0;
      ovf_q      <= 1'b0;
      racha_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      ovf_q      <= ovf_d;
      racha_q    <= racha_d;
    end
  end

  // Storage needs no reset: pointers and counts define what is live
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= din[i];
    end
  end

  assign bus.full0     = full[0];
  assign bus.empty0    = empty[0];
  assign bus.full1     = full[1];
  assign bus.empty1    = empty[1];
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_q;
  assign bus.selector  = sel_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_arbitro_mux_memoria.sv
// Directed bench for arbitro_mux_memoria with default parameters (2-bit data, depth 4, quantum 2).
module tb_arbitro_mux_memoria;
  logic clk;
  logic reset_L;
  int   passed;
  int   total;

  arbitro_mux_memoria_if #(.DATA_WIDTH(2)) bus ();

  arbitro_mux_memoria #(
    .DATA_WIDTH(2),
    .FIFO_DEPTH(4),
    .QUANTUM   (2)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] d, input logic v, input logic s);
    check({tag, ".data"}, 32'(bus.data_out), 32'(d));
    check({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
    check({tag, ".sel"}, 32'(bus.selector), 32'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check_out(tag, 2'd0, 1'b0, 1'b0);
    check({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, ".full0"}, 32'(bus.full0), 32'd0);
    check({tag, ".full1"}, 32'(bus.full1), 32'd0);
    check({tag, ".empty0"}, 32'(bus.empty0), 32'd1);
    check({tag, ".empty1"}, 32'(bus.empty1), 32'd1);
  endtask

  initial begin
    logic [1:0] q_data [8];
    logic       q_lane [8];
    q_data = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
    q_lane = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    passed = 0;
    total  = 0;
    reset_L      = 1'b1;
    bus.push0    = 1'b0;
    bus.data_in0 = '0;
    bus.push1    = 1'b0;
    bus.data_in1 = '0;
    bus.pause    = 1'b0;
    #1 reset_L = 1'b0;
    tick();
    tick();
    check_reset_vals("por");
    reset_L = 1'b1;

    // Single lane: 1,2,3 through lane 0
    bus.push0 = 1'b1; bus.data_in0 = 2'd1;
    tick();
    check("sl.empty0", 32'(bus.empty0), 32'd0);
    check("sl.valid_n", 32'(bus.valid_out), 32'd0);
    bus.data_in0 = 2'd2;
    tick();
    check_out("sl.w1", 2'd1, 1'b1, 1'b0);
    bus.data_in0 = 2'd3;
    tick();
    check_out("sl.w2", 2'd2, 1'b1, 1'b0);
    bus.push0 = 1'b0;
    tick();
    check_out("sl.w3", 2'd3, 1'b1, 1'b0);
    tick();
    check_out("sl.idle", 2'd3, 1'b0, 1'b0);
    check("sl.empty0_end", 32'(bus.empty0), 32'd1);
    check("sl.empty1", 32'(bus.empty1), 32'd1);

    // Full/overflow on lane 1
    bus.pause = 1'b1;
    bus.push1 = 1'b1;
    bus.data_in1 = 2'd1; tick();
    bus.data_in1 = 2'd2; tick();
    bus.data_in1 = 2'd3; tick();
    check("ov.full1_3", 32'(bus.full1), 32'd0);
    bus.data_in1 = 2'd0; tick();
    check("ov.full1_4", 32'(bus.full1), 32'd1);
    check("ov.ovf_4", 32'(bus.overflow), 32'd0);
    bus.data_in1 = 2'd1; tick();
    check("ov.ovf_5", 32'(bus.overflow), 32'd1);
    check("ov.full1_5", 32'(bus.full1), 32'd1);
    check("ov.valid_paused", 32'(bus.valid_out), 32'd0);
    bus.push1 = 1'b0;
    bus.pause = 1'b0;
    tick(); check_out("ov.o1", 2'd1, 1'b1, 1'b1);
    check("ov.full1_drop", 32'(bus.full1), 32'd0);
    tick(); check_out("ov.o2", 2'd2, 1'b1, 1'b1);
    tick(); check_out("ov.o3", 2'd3, 1'b1, 1'b1);
    tick(); check_out("ov.o4", 2'd0, 1'b1, 1'b1);
    check("ov.empty1", 32'(bus.empty1), 32'd1);
    tick(); check_out("ov.idle", 2'd0, 1'b0, 1'b1);
    check("ov.sticky", 32'(bus.overflow), 32'd1);

    // Load both lanes, take one pop, then reset asynchronously mid-cycle
    bus.pause = 1'b1;
    bus.push0 = 1'b1; bus.push1 = 1'b1;
    bus.data_in0 = 2'd2; bus.data_in1 = 2'd1; tick();
    bus.data_in0 = 2'd3; bus.data_in1 = 2'd2; tick();
    bus.push0 = 1'b0; bus.push1 = 1'b0;
    bus.pause = 1'b0;
    tick();
    bus.pause = 1'b1;
    check_out("rs.pre", 2'd2, 1'b1, 1'b0);
    check("rs.pre_ovf", 32'(bus.overflow), 32'd1);
    #2 reset_L = 1'b0;
    #1 check_reset_vals("rs.async");
    tick();
    reset_L = 1'b1;
    bus.pause = 1'b0;
    bus.push0 = 1'b1; bus.data_in0 = 2'd1;
    tick();
    bus.push0 = 1'b0;
    check("rs.empty0", 32'(bus.empty0), 32'd0);
    check("rs.valid_n", 32'(bus.valid_out), 32'd0);
    tick();
    check_out("rs.first", 2'd1, 1'b1, 1'b0);
    tick();
    check("rs.discard_v", 32'(bus.valid_out), 32'd0);
    check("rs.discard_e1", 32'(bus.empty1), 32'd1);

    // Reset pulse so arbitration starts from racha=0, selector=0
    #2 reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    bus.pause = 1'b1;
    bus.push0 = 1'b1; bus.push1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in0 = 2'(i);
      bus.data_in1 = 2'(3 - i);
      tick();
    end
    bus.push0 = 1'b0; bus.push1 = 1'b0;
    check("qt.full0", 32'(bus.full0), 32'd1);
    check("qt.full1", 32'(bus.full1), 32'd1);
    bus.pause = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out($sformatf("qt.pop%0d", i), q_data[i], 1'b1, q_lane[i]);
    end
    tick();
    check("qt.idle_v", 32'(bus.valid_out), 32'd0);
    check("qt.idle_e0", 32'(bus.empty0), 32'd1);
    check("qt.idle_e1", 32'(bus.empty1), 32'd1);

    // Pause mid-stream on lane 0
    bus.pause = 1'b1;
    bus.push0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in0 = 2'(i);
      tick();
    end
    bus.push0 = 1'b0;
    bus.pause = 1'b0;
    tick();
    check_out("pz.first", 2'd0, 1'b1, 1'b0);
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("pz.hold%0d", i), 2'd0, 1'b0, 1'b0);
    end
    bus.pause = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_out($sformatf("pz.res%0d", i), 2'(i), 1'b1, 1'b0);
    end
    tick();
    check("pz.end_v", 32'(bus.valid_out), 32'd0);
    check("pz.end_e0", 32'(bus.empty0), 32'd1);

    // Simultaneous push/pop keeps lane 0 at two entries
    bus.pause = 1'b1;
    bus.push0 = 1'b1;
    bus.data_in0 = 2'd0; tick();
    bus.data_in0 = 2'd1; tick();
    bus.pause = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.data_in0 = 2'(i + 2);
      tick();
      check_out($sformatf("sp.pop%0d", i), 2'(i), 1'b1, 1'b0);
      check($sformatf("sp.full%0d", i), 32'(bus.full0), 32'd0);
      check($sformatf("sp.empty%0d", i), 32'(bus.empty0), 32'd0);
    end
    bus.push0 = 1'b0;
    tick(); check_out("sp.drain0", 2'd2, 1'b1, 1'b0);
    tick(); check_out("sp.drain1", 2'd3, 1'b1, 1'b0);
    check("sp.drain_e0", 32'(bus.empty0), 32'd1);
    tick(); check_out("sp.idle", 2'd3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
